// File: rtl/pll_sys_clkgen.sv
// pll_sys_clkgen: qualifies the raw PLL lock, releases per-channel
// synchronous resets in a staggered sequence, and generates a programmable
// ratio/phase clock enable plus a divided square wave per channel.
// Every output is a plain data signal in the refclk domain.
// Loss of lock after release has begun tears all channels down and sets
// a sticky lock_lost flag.
//
// Debug: dbg_state reports the sequencer state
//   0 = WAIT_LOCK, 1 = STABLE, 2 = RELEASE, 3 = RUN.
module pll_sys_clkgen #(
  parameter int NUM_CH      = 4,
  parameter int DIV_W       = 16,
  parameter int SYNC_STAGES = 2,
  parameter int LOCK_STABLE = 1024,
  parameter int RST_STAGGER = 16
) (
  input  logic                    refclk,
  input  logic                    rst_n,
  input  logic                    pll_locked,
  input  logic [NUM_CH*DIV_W-1:0] cfg_div,
  input  logic [NUM_CH*DIV_W-1:0] cfg_phase,
  input  logic                    cfg_load,
  input  logic                    lost_clr,
  output logic [NUM_CH-1:0]       ce,
  output logic [NUM_CH-1:0]       div_clk,
  output logic [NUM_CH-1:0]       ch_rst_n,
  output logic                    locked_out,
  output logic                    lock_lost,
  output logic [1:0]              dbg_state
);

  // Stability counter must be able to hold LOCK_STABLE-1.
  localparam int STAB_W  = $clog2(LOCK_STABLE + 1);
  // Release counter runs up to the last channel's release offset.
  localparam int REL_MAX = (NUM_CH - 1) * RST_STAGGER;
  localparam int REL_W   = $clog2(REL_MAX + 2);

  typedef enum logic [1:0] {
    ST_WAIT_LOCK = 2'd0,
    ST_STABLE    = 2'd1,
    ST_RELEASE   = 2'd2,
    ST_RUN       = 2'd3
  } state_t;

  // ------------------------------------------------------------------
  // Lock synchroniser
  // ------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_lk_s;

  // Shift the asynchronous lock through SYNC_STAGES flops.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], pll_locked};
    end
  end

  assign w_lk_s = r_sync[SYNC_STAGES-1];

  // ------------------------------------------------------------------
  // Sequencer FSM
  // ------------------------------------------------------------------
  state_t              r_state;
  state_t              w_state_nxt;
  logic [STAB_W-1:0]   r_stab_cnt;
  logic [STAB_W-1:0]   w_stab_nxt;
  logic [REL_W-1:0]    r_rel_cnt;
  logic [REL_W-1:0]    w_rel_nxt;
  logic [REL_W-1:0]    w_rel_inc;
  logic [NUM_CH-1:0]   r_ch_rst_n;
  logic [NUM_CH-1:0]   w_ch_rst_nxt;
  logic                w_rel_entry;
  logic                w_teardown;

  assign w_rel_inc = r_rel_cnt + REL_W'(1);

  // State register together with the counters and reset vector it owns.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_WAIT_LOCK;
      r_stab_cnt <= '0;
      r_rel_cnt  <= '0;
      r_ch_rst_n <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_stab_cnt <= w_stab_nxt;
      r_rel_cnt  <= w_rel_nxt;
      r_ch_rst_n <= w_ch_rst_nxt;
    end
  end

  // Next-state logic: qualify lock, stagger resets, tear down on loss.
  always_comb begin
    w_state_nxt  = r_state;
    w_stab_nxt   = r_stab_cnt;
    w_rel_nxt    = r_rel_cnt;
    w_ch_rst_nxt = r_ch_rst_n;
    w_rel_entry  = 1'b0;
    w_teardown   = 1'b0;
    case (r_state)
      ST_WAIT_LOCK: begin
        w_stab_nxt   = '0;
        w_rel_nxt    = '0;
        w_ch_rst_nxt = '0;
        if (w_lk_s) begin
          w_state_nxt = ST_STABLE;
        end
      end
      ST_STABLE: begin
        w_ch_rst_nxt = '0;
        w_rel_nxt    = '0;
        if (!w_lk_s) begin
          // Any dropout restarts qualification from zero.
          w_state_nxt = ST_WAIT_LOCK;
          w_stab_nxt  = '0;
        end else if (r_stab_cnt == STAB_W'(LOCK_STABLE - 1)) begin
          w_state_nxt     = ST_RELEASE;
          w_stab_nxt      = '0;
          w_rel_entry     = 1'b1;
          w_ch_rst_nxt[0] = 1'b1;
        end else begin
          w_stab_nxt = r_stab_cnt + STAB_W'(1);
        end
      end
      ST_RELEASE: begin
        if (!w_lk_s) begin
          w_teardown   = 1'b1;
          w_state_nxt  = ST_WAIT_LOCK;
          w_rel_nxt    = '0;
          w_ch_rst_nxt = '0;
        end else begin
          w_rel_nxt = w_rel_inc;
          // Channel k comes out of reset k*RST_STAGGER cycles after channel 0.
          for (int k = 0; k < NUM_CH; k++) begin
            if (w_rel_inc >= REL_W'(k * RST_STAGGER)) begin
              w_ch_rst_nxt[k] = 1'b1;
            end
          end
          // Last channel was released on the previous edge.
          if (r_rel_cnt == REL_W'(REL_MAX)) begin
            w_state_nxt = ST_RUN;
            w_rel_nxt   = '0;
          end
        end
      end
      ST_RUN: begin
        if (!w_lk_s) begin
          w_teardown   = 1'b1;
          w_state_nxt  = ST_WAIT_LOCK;
          w_ch_rst_nxt = '0;
        end else begin
          w_ch_rst_nxt = '1;
        end
      end
      default: begin
        w_state_nxt  = ST_WAIT_LOCK;
        w_stab_nxt   = '0;
        w_rel_nxt    = '0;
        w_ch_rst_nxt = '0;
      end
    endcase
  end

  // ------------------------------------------------------------------
  // Sticky lock-loss flag: a new loss beats a simultaneous clear.
  // ------------------------------------------------------------------
  logic r_lost;

  // Set on teardown, cleared by lost_clr otherwise.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      r_lost <= 1'b0;
    end else if (w_teardown) begin
      r_lost <= 1'b1;
    end else if (lost_clr) begin
      r_lost <= 1'b0;
    end
  end

  // ------------------------------------------------------------------
  // Configuration shadows
  // ------------------------------------------------------------------
  logic [NUM_CH*DIV_W-1:0] r_sh_div;
  logic [NUM_CH*DIV_W-1:0] r_sh_ph;
  logic [NUM_CH*DIV_W-1:0] w_sh_div_nxt;
  logic [NUM_CH*DIV_W-1:0] w_sh_ph_nxt;
  logic                    w_capture;

  // Shadows take the inputs on a load strobe and again at release entry.
  assign w_capture    = cfg_load | w_rel_entry;
  assign w_sh_div_nxt = w_capture ? cfg_div   : r_sh_div;
  assign w_sh_ph_nxt  = w_capture ? cfg_phase : r_sh_ph;

  // Shadow registers.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      r_sh_div <= '0;
      r_sh_ph  <= '0;
    end else begin
      r_sh_div <= w_sh_div_nxt;
      r_sh_ph  <= w_sh_ph_nxt;
    end
  end

  // ------------------------------------------------------------------
  // Per-channel divider
  // ------------------------------------------------------------------
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic [DIV_W-1:0] w_d_cur;
    logic [DIV_W-1:0] w_de_cur;
    logic [DIV_W-1:0] w_half;
    logic [DIV_W-1:0] w_d_nxt;
    logic [DIV_W-1:0] w_de_nxt;
    logic [DIV_W-1:0] w_p_nxt;
    logic [DIV_W-1:0] w_pe_nxt;
    logic [DIV_W-1:0] r_cnt;
    logic             w_term;
    logic             r_ce_q;
    logic             r_div_q;

    // Active ratio; zero behaves as one.
    assign w_d_cur  = r_sh_div[g*DIV_W +: DIV_W];
    assign w_de_cur = (w_d_cur == '0) ? DIV_W'(1) : w_d_cur;
    assign w_half   = w_de_cur >> 1;
    assign w_term   = (r_cnt == w_de_cur - DIV_W'(1));

    // Start count from the shadows as they will be after this edge, so a
    // counter realigned on a capture edge already uses the new phase.
    assign w_d_nxt  = w_sh_div_nxt[g*DIV_W +: DIV_W];
    assign w_de_nxt = (w_d_nxt == '0) ? DIV_W'(1) : w_d_nxt;
    assign w_p_nxt  = w_sh_ph_nxt[g*DIV_W +: DIV_W];
    assign w_pe_nxt = (w_p_nxt < w_de_nxt) ? w_p_nxt : '0;

    // Phase counter: held at the start count in reset, realigned on load.
    always_ff @(posedge refclk or negedge rst_n) begin
      if (!rst_n) begin
        r_cnt <= '0;
      end else if (!r_ch_rst_n[g] || cfg_load) begin
        r_cnt <= w_pe_nxt;
      end else if (w_term) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + DIV_W'(1);
      end
    end

    // Registered enable and square wave, both cleared on teardown.
    always_ff @(posedge refclk or negedge rst_n) begin
      if (!rst_n) begin
        r_ce_q  <= 1'b0;
        r_div_q <= 1'b0;
      end else begin
        r_ce_q  <= r_ch_rst_n[g] & w_term & ~cfg_load & ~w_teardown;
        r_div_q <= r_ch_rst_n[g] & (r_cnt < w_half) & ~w_teardown;
      end
    end

    assign ce[g]      = r_ce_q;
    assign div_clk[g] = r_div_q;
  end

  // ------------------------------------------------------------------
  // Outputs
  // ------------------------------------------------------------------
  assign ch_rst_n   = r_ch_rst_n;
  assign locked_out = (r_state == ST_RUN);
  assign lock_lost  = r_lost;
  assign dbg_state  = r_state;

endmodule
